// File: rtl/rob_param.sv
// In-order reorder buffer: allocates DISPATCH_W/cycle, completes from WB_PORTS, retires up to COMMIT_W/cycle combinationally, registered 1-cycle flush.
// disp_ready drops below DISPATCH_W free entries or during flush; `ROB_DELAY_SLOT_EN` pairs each branch with its delay slot at commit.
module rob_param #(
  parameter int DEPTH      = 16,
  parameter int DISPATCH_W = 2,
  parameter int COMMIT_W   = 2,
  parameter int WB_PORTS   = 3,
  parameter int PAYLOAD_W  = 64,
  parameter int EXC_W      = 5,
  localparam int IDXW      = $clog2(DEPTH)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [DISPATCH_W-1:0]           disp_valid,
  input  logic [DISPATCH_W-1:0]           disp_is_br,
  input  logic [DISPATCH_W*PAYLOAD_W-1:0] disp_payload,
  output logic                            disp_ready,
  output logic [DISPATCH_W*IDXW-1:0]      disp_idx,
  input  logic [WB_PORTS-1:0]             wb_valid,
  input  logic [WB_PORTS*IDXW-1:0]        wb_idx,
  input  logic [WB_PORTS-1:0]             wb_ex,
  input  logic [WB_PORTS*EXC_W-1:0]       wb_exccode,
  input  logic [WB_PORTS-1:0]             wb_mispredict,
  output logic [COMMIT_W-1:0]             commit_valid,
  output logic [COMMIT_W*PAYLOAD_W-1:0]   commit_payload,
  output logic                            flush,
  output logic                            flush_ex,
  output logic [EXC_W-1:0]                flush_exccode,
  output logic                            flush_bd,
  output logic [PAYLOAD_W-1:0]            flush_payload,
  output logic [IDXW:0]                   count,
  output logic                            empty
);

  typedef logic [IDXW:0]   ptr_t;
  typedef logic [IDXW-1:0] idx_t;

  typedef struct packed {
    logic             vld;
    logic             cmp;
    logic             ex;
    logic             mis;
    logic             br;
    logic [EXC_W-1:0] exccode;
  } ent_t;

  localparam ptr_t DEPTH_P = ptr_t'(DEPTH);

  // One extra lookahead slot is needed to see a branch's delay slot.
`ifdef ROB_DELAY_SLOT_EN
  localparam int OKN = COMMIT_W + 1;
`else
  localparam int OKN = COMMIT_W;
`endif

  ent_t                 ent [DEPTH];
  logic [PAYLOAD_W-1:0] pay [DEPTH];
  ptr_t                 head;
  ptr_t                 tail;

  idx_t            slot_idx [OKN];
  idx_t            disp_at  [DISPATCH_W];
  idx_t            wb_at    [WB_PORTS];
  logic [OKN-1:0]  ok;
  logic [COMMIT_W-1:0] ret;
  ptr_t            ret_cnt;
  ptr_t            disp_cnt;
  logic            go;
  logic            pair;
  logic            misp_fire;
  idx_t            misp_src;
  logic            exc_fire;
  logic            exc_bd;
  logic [EXC_W-1:0] exc_code;
  logic            kill;
  idx_t            flush_src;
  logic            alloc;

  assign count      = tail - head;
  assign empty      = (count == '0);
  assign disp_ready = !flush && ((DEPTH_P - count) >= ptr_t'(DISPATCH_W));
  assign alloc      = disp_valid[0] && disp_ready;

  always_comb begin
    disp_cnt = '0;
    for (int k = 0; k < DISPATCH_W; k++) begin
      disp_at[k] = tail[IDXW-1:0] + idx_t'(k);
      disp_idx[k*IDXW +: IDXW] = disp_at[k];
      disp_cnt = disp_cnt + ptr_t'(disp_valid[k]);
    end
    for (int p = 0; p < WB_PORTS; p++) begin
      wb_at[p] = wb_idx[p*IDXW +: IDXW];
    end
  end

  always_comb begin
    for (int k = 0; k < OKN; k++) begin
      slot_idx[k] = head[IDXW-1:0] + idx_t'(k);
      ok[k] = (ptr_t'(k) < count) && ent[slot_idx[k]].vld &&
              ent[slot_idx[k]].cmp && !ent[slot_idx[k]].ex;
    end
  end

  // Retire window: prefix of ready entries, cut after a mispredicted branch.
  always_comb begin
    ret       = '0;
    go        = !flush;
    pair      = 1'b0;
    misp_fire = 1'b0;
    misp_src  = slot_idx[0];
    for (int k = 0; k < COMMIT_W; k++) begin
`ifdef ROB_DELAY_SLOT_EN
      if (go && pair) begin
        ret[k] = 1'b1;
        pair   = 1'b0;
        if (misp_fire) go = 1'b0;
      end else if (go && ok[k] && ent[slot_idx[k]].br) begin
        if ((k < COMMIT_W-1) && ok[k+1]) begin
          ret[k] = 1'b1;
          pair   = 1'b1;
          if (ent[slot_idx[k]].mis) begin
            misp_fire = 1'b1;
            misp_src  = slot_idx[k];
          end
        end else begin
          go = 1'b0;
        end
      end else if (go && ok[k]) begin
        ret[k] = 1'b1;
      end else begin
        go = 1'b0;
      end
`else
      if (go && ok[k]) begin
        ret[k] = 1'b1;
        if (ent[slot_idx[k]].br && ent[slot_idx[k]].mis) begin
          misp_fire = 1'b1;
          misp_src  = slot_idx[k];
          go        = 1'b0;
        end
      end else begin
        go = 1'b0;
      end
`endif
    end
  end

  always_comb begin
    exc_fire = 1'b0;
    exc_bd   = 1'b0;
    exc_code = '0;
    if (!flush && !empty && ent[slot_idx[0]].vld && ent[slot_idx[0]].cmp && ent[slot_idx[0]].ex) begin
      exc_fire = 1'b1;
      exc_code = ent[slot_idx[0]].exccode;
    end
`ifdef ROB_DELAY_SLOT_EN
    // Faulting delay slot: report against the branch so EPC points at it.
    else if (!flush && ok[0] && ent[slot_idx[0]].br && ent[slot_idx[1]].vld &&
             ent[slot_idx[1]].cmp && ent[slot_idx[1]].ex) begin
      exc_fire = 1'b1;
      exc_bd   = 1'b1;
      exc_code = ent[slot_idx[1]].exccode;
    end
`endif
  end

  always_comb begin
    ret_cnt = '0;
    for (int k = 0; k < COMMIT_W; k++) begin
      ret_cnt = ret_cnt + ptr_t'(ret[k]);
      commit_payload[k*PAYLOAD_W +: PAYLOAD_W] = ret[k] ? pay[slot_idx[k]] : '0;
    end
  end

  assign commit_valid = ret;
  assign kill         = misp_fire || exc_fire;
  assign flush_src    = misp_fire ? misp_src : slot_idx[0];

  always_ff @(posedge clk) begin
    if (reset) begin
      head          <= '0;
      tail          <= '0;
      flush         <= 1'b0;
      flush_ex      <= 1'b0;
      flush_exccode <= '0;
      flush_bd      <= 1'b0;
      flush_payload <= '0;
      for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
    end else begin
      flush         <= kill;
      flush_ex      <= exc_fire;
      flush_exccode <= exc_fire ? exc_code : '0;
      flush_bd      <= exc_fire && exc_bd;
      flush_payload <= kill ? pay[flush_src] : '0;
      if (kill) begin
        head <= '0;
        tail <= '0;
        for (int i = 0; i < DEPTH; i++) ent[i].vld <= 1'b0;
      end else begin
        head <= head + ret_cnt;
        for (int k = 0; k < COMMIT_W; k++) begin
          if (ret[k]) ent[slot_idx[k]].vld <= 1'b0;
        end
        // Descending loop so the lowest-numbered port has the final say.
        if (!flush) begin
          for (int p = WB_PORTS-1; p >= 0; p--) begin
            if (wb_valid[p] && ent[wb_at[p]].vld) begin
              ent[wb_at[p]].cmp     <= 1'b1;
              ent[wb_at[p]].ex      <= wb_ex[p];
              ent[wb_at[p]].mis     <= wb_mispredict[p];
              ent[wb_at[p]].exccode <= wb_exccode[p*EXC_W +: EXC_W];
            end
          end
        end
        if (alloc) begin
          tail <= tail + disp_cnt;
          for (int k = 0; k < DISPATCH_W; k++) begin
            if (disp_valid[k]) begin
              ent[disp_at[k]].vld     <= 1'b1;
              ent[disp_at[k]].cmp     <= 1'b0;
              ent[disp_at[k]].ex      <= 1'b0;
              ent[disp_at[k]].mis     <= 1'b0;
              ent[disp_at[k]].br      <= disp_is_br[k];
              ent[disp_at[k]].exccode <= '0;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (alloc) begin
      for (int k = 0; k < DISPATCH_W; k++) begin
        if (disp_valid[k]) pay[disp_at[k]] <= disp_payload[k*PAYLOAD_W +: PAYLOAD_W];
      end
    end
  end

endmodule

// File: tb/tb_rob_param.sv
// Bench for rob_param: directed stimulus pushes expected commits/flushes into queues, a negedge monitor pops and compares.
module tb_rob_param;

  typedef struct packed {
    logic        ex;
    logic [4:0]  code;
    logic        bd;
    logic [63:0] pay;
  } fl_t;

  logic         clk = 1'b0;
  logic         reset;
  logic [1:0]   disp_valid;
  logic [1:0]   disp_is_br;
  logic [127:0] disp_payload;
  logic         disp_ready;
  logic [7:0]   disp_idx;
  logic [2:0]   wb_valid;
  logic [11:0]  wb_idx;
  logic [2:0]   wb_ex;
  logic [14:0]  wb_exccode;
  logic [2:0]   wb_mispredict;
  logic [1:0]   commit_valid;
  logic [127:0] commit_payload;
  logic         flush;
  logic         flush_ex;
  logic [4:0]   flush_exccode;
  logic         flush_bd;
  logic [63:0]  flush_payload;
  logic [4:0]   count;
  logic         empty;

  int n_chk  = 0;
  int n_fail = 0;
  int tm     = 0;
  logic [63:0] exp_commit[$];
  fl_t         exp_flush[$];

  always #5 clk = ~clk;

  rob_param dut (
    .clk(clk), .reset(reset),
    .disp_valid(disp_valid), .disp_is_br(disp_is_br), .disp_payload(disp_payload),
    .disp_ready(disp_ready), .disp_idx(disp_idx),
    .wb_valid(wb_valid), .wb_idx(wb_idx), .wb_ex(wb_ex), .wb_exccode(wb_exccode),
    .wb_mispredict(wb_mispredict),
    .commit_valid(commit_valid), .commit_payload(commit_payload),
    .flush(flush), .flush_ex(flush_ex), .flush_exccode(flush_exccode), .flush_bd(flush_bd),
    .flush_payload(flush_payload), .count(count), .empty(empty)
  );

  function automatic logic [63:0] mkpay(input int n);
    return {32'hB00B_0000 + 32'(n), 32'hC0DE_0000 ^ 32'(n)};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_disp(input logic [1:0] br, input int n0, input logic push0, input logic push1);
    chk("disp_ready", 64'(disp_ready), 64'(1));
    chk("disp_idx", 64'(disp_idx), 64'({4'(tm+1), 4'(tm)}));
    disp_valid   = 2'b11;
    disp_is_br   = br;
    disp_payload = {mkpay(n0+1), mkpay(n0)};
    if (push0) exp_commit.push_back(mkpay(n0));
    if (push1) exp_commit.push_back(mkpay(n0+1));
    tick();
    disp_valid = '0;
    disp_is_br = '0;
    tm += 2;
  endtask

  task automatic do_wb(input logic [2:0] v, input int i0, input int i1, input int i2,
                       input logic [2:0] ex, input logic [2:0] mis, input logic [4:0] code);
    wb_valid      = v;
    wb_idx        = {4'(i2), 4'(i1), 4'(i0)};
    wb_ex         = ex;
    wb_mispredict = mis;
    wb_exccode    = {3{code}};
    tick();
    wb_valid      = '0;
    wb_ex         = '0;
    wb_mispredict = '0;
  endtask

  task automatic wait_flush(input string name);
    logic got;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      got = flush;
    end
    chk(name, 64'(got), 64'(1));
  endtask

  task automatic wait_empty(input string name);
    logic got;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      got = empty;
    end
    chk(name, 64'(got), 64'(1));
  endtask

  // Monitor: every retiring slot and every flush pulse must match the next queued expectation.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (commit_valid != 2'b00) chk("commit_prefix", 64'(commit_valid == 2'b10), 64'(0));
        for (int k = 0; k < 2; k++) begin
          if (commit_valid[k]) begin
            if (exp_commit.size() == 0) begin
              n_chk++; n_fail++;
              $display("FAIL commit_unexpected: got 0x%0h, expected no commit", commit_payload[k*64 +: 64]);
            end else begin
              chk("commit_payload", commit_payload[k*64 +: 64], exp_commit.pop_front());
            end
          end
        end
        if (flush) begin
          if (exp_flush.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL flush_unexpected: got flush=1, expected no flush");
          end else begin
            fl_t e;
            e = exp_flush.pop_front();
            chk("flush_ex", 64'(flush_ex), 64'(e.ex));
            chk("flush_exccode", 64'(flush_exccode), 64'(e.code));
            chk("flush_bd", 64'(flush_bd), 64'(e.bd));
            chk("flush_payload", flush_payload, e.pay);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    reset = 1'b1; disp_valid = '0; disp_is_br = '0; disp_payload = '0;
    wb_valid = '0; wb_idx = '0; wb_ex = '0; wb_exccode = '0; wb_mispredict = '0;
    repeat (3) tick();
    reset = 1'b0;
    chk("rst_count", 64'(count), 64'(0));
    chk("rst_empty", 64'(empty), 64'(1));
    chk("rst_ready", 64'(disp_ready), 64'(1));
    chk("rst_flush", 64'(flush), 64'(0));
    chk("rst_flush_payload", flush_payload, 64'(0));
    chk("rst_commit", 64'(commit_valid), 64'(0));

    // Fill: 8 cycles of 2 dispatches, then backpressure with no overflow.
    for (int c = 0; c < 8; c++) do_disp(2'b00, 2*c, 1'b1, 1'b1);
    chk("fill_count", 64'(count), 64'(16));
    chk("fill_ready", 64'(disp_ready), 64'(0));
    chk("fill_empty", 64'(empty), 64'(0));
    disp_valid = 2'b11; disp_payload = {mkpay(998), mkpay(999)};
    tick();
    disp_valid = '0;
    chk("fill_no_overflow", 64'(count), 64'(16));
    for (int i = 0; i < 16; i += 3) do_wb((i == 15) ? 3'b001 : 3'b111, i, i+1, i+2, 3'b0, 3'b0, 5'h0);
    wait_empty("fill_drain");

    // Wrap: 40 entries, completed in reverse order within each group of 4.
    tick();
    for (int g = 0; g < 10; g++) begin
      base = tm;
      do_disp(2'b00, 100 + 4*g, 1'b1, 1'b1);
      do_disp(2'b00, 102 + 4*g, 1'b1, 1'b1);
      for (int j = 3; j >= 0; j--) do_wb(3'(1 << ((3-j) % 3)), base+j, base+j, base+j, 3'b0, 3'b0, 5'h0);
      tick(); tick();
    end
    wait_empty("wrap_drain");

    // Mispredict at idx 5: 0..5 retire, 6..7 killed.
    tick();
    reset = 1'b1; tick(); reset = 1'b0; tm = 0;
    do_disp(2'b00, 300, 1'b1, 1'b1);
    do_disp(2'b00, 302, 1'b1, 1'b1);
    do_disp(2'b10, 304, 1'b1, 1'b1);
    do_disp(2'b00, 306, 1'b0, 1'b0);
    exp_flush.push_back('{ex: 1'b0, code: 5'h0, bd: 1'b0, pay: mkpay(305)});
    do_wb(3'b111, 0, 1, 2, 3'b0, 3'b000, 5'h0);
    do_wb(3'b111, 3, 4, 5, 3'b0, 3'b100, 5'h0);
    do_wb(3'b011, 6, 7, 0, 3'b0, 3'b000, 5'h0);
    wait_flush("misp_flush_seen");
    chk("misp_count", 64'(count), 64'(0));
    chk("misp_ready", 64'(disp_ready), 64'(0));
    chk("misp_commit", 64'(commit_valid), 64'(0));
    tick(); tm = 0;
    chk("misp_idx_restart", 64'(disp_idx[3:0]), 64'(0));

    // Exception at idx 3 (code 0x0C); a writeback to an unoccupied index is ignored first.
    do_wb(3'b001, 9, 0, 0, 3'b001, 3'b0, 5'h1F);
    chk("wb_unoccupied", 64'(count), 64'(0));
    do_disp(2'b00, 400, 1'b1, 1'b1);
    do_disp(2'b00, 402, 1'b1, 1'b0);
    do_disp(2'b00, 404, 1'b0, 1'b0);
    exp_flush.push_back('{ex: 1'b1, code: 5'h0C, bd: 1'b0, pay: mkpay(403)});
    do_wb(3'b111, 0, 1, 2, 3'b000, 3'b0, 5'h0);
    do_wb(3'b111, 3, 4, 5, 3'b001, 3'b0, 5'h0C);
    wait_flush("exc_flush_seen");
    chk("exc_count", 64'(count), 64'(0));
    tick(); tm = 0;

    // Reset with a full ROB.
    for (int c = 0; c < 8; c++) do_disp(2'b00, 500 + 2*c, 1'b0, 1'b0);
    chk("full_count", 64'(count), 64'(16));
    reset = 1'b1; tick();
    chk("rst_full_count", 64'(count), 64'(0));
    chk("rst_full_ready", 64'(disp_ready), 64'(1));
    chk("rst_full_empty", 64'(empty), 64'(1));
    reset = 1'b0; tm = 0;

    // Reset asserted during the flush cycle.
    do_disp(2'b10, 600, 1'b1, 1'b1);
    do_wb(3'b011, 0, 1, 0, 3'b0, 3'b010, 5'h0);
    tick();
    chk("pre_reset_flush", 64'(flush), 64'(1));
    reset = 1'b1; tick();
    chk("rst_flush_flush", 64'(flush), 64'(0));
    chk("rst_flush_count", 64'(count), 64'(0));
    chk("rst_flush_ready", 64'(disp_ready), 64'(1));
    chk("rst_flush_commit", 64'(commit_valid), 64'(0));
    reset = 1'b0; tm = 0;

`ifdef ROB_DELAY_SLOT_EN
    // Branch in the last commit slot waits, then retires with its delay slot.
    do_disp(2'b10, 700, 1'b1, 1'b1);
    do_disp(2'b00, 702, 1'b1, 1'b1);
    do_wb(3'b111, 0, 1, 2, 3'b0, 3'b0, 5'h0);
    @(negedge clk);
    chk("ds_wait", 64'(commit_valid), 64'(2'b01));
    @(negedge clk);
    chk("ds_pair", 64'(commit_valid), 64'(2'b11));
    tick();
    // Delay slot faults: neither retires, EPC is the branch.
    do_disp(2'b01, 704, 1'b0, 1'b0);
    exp_flush.push_back('{ex: 1'b1, code: 5'h04, bd: 1'b1, pay: mkpay(704)});
    do_wb(3'b111, 3, 4, 5, 3'b100, 3'b0, 5'h04);
    wait_flush("ds_flush_seen");
    tick();
`endif

    tick(); tick();
    chk("commit_queue_drained", 64'(exp_commit.size()), 64'(0));
    chk("flush_queue_drained", 64'(exp_flush.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
